serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor that computes a - b, LSB first, one bit per clock.
//   Each cycle it applies a half-subtract of a[i] and b[i], then subtracts the stored borrow.
//   A single borrow flip-flop carries the borrow from bit i to bit i+1.
//   It sits downstream of the combinational subtract cells and turns them into a
//   multi-bit, area-lean sequential datapath with a start/done handshake.
// PARAMETERS
//   WIDTH   8   operand and result width in bits; legal range 1..32
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       request; sampled on the rising edge of clk
//   a           in   WIDTH   minuend; captured when start is accepted
//   b           in   WIDTH   subtrahend; captured when start is accepted
//   busy        out  1       high while bits are being processed
//   done        out  1       one-cycle pulse; diff and borrow_out are valid
//   diff        out  WIDTH   (a - b) mod 2^WIDTH
//   borrow_out  out  1       final borrow; 1 iff a < b (unsigned)
// BEHAVIOUR
//   Reset (async, takes effect immediately)
//   - State -> IDLE.
//   - busy, done, diff and borrow_out all go to 0.
//   - The shift registers, borrow flop and bit counter are cleared.
//   State IDLE
//   - busy=0, done=0.
//   - start=1 at an edge: load A_sh<=a, B_sh<=b, borrow flop<=0, count<=0, go to SHIFT.
//   State SHIFT (busy=1)
//   - Each edge uses the LSBs of the shift registers:
//     - d_i = A_sh[0] ^ B_sh[0] ^ bq
//     - bq <= (~A_sh[0] & B_sh[0]) | (~(A_sh[0] ^ B_sh[0]) & bq)
//   - A_sh and B_sh shift right by one bit.
//   - d_i shifts into the MSB of an internal result register R; count increments.
//   - On the edge that processes bit WIDTH-1:
//     - diff <= final R value (including this bit).
//     - borrow_out <= the final borrow (same expression as bq).
//     - Go to DONE.
//   - start is ignored in SHIFT; the operands in flight are unaffected.
//   State DONE (busy=0, done=1 for exactly one cycle)
//   - start=1: accept it exactly as in IDLE and go to SHIFT (back-to-back operation).
//   - Otherwise go to IDLE.
//   Latency and output holding
//   - start accepted at edge N -> done=1 during the cycle after edge N+WIDTH.
//   - Throughput is one result per WIDTH+1 cycles when start is held high.
//   - diff and borrow_out change only on the completing edge or on reset.
//   - They hold their value between operations and are not updated bit by bit.
//   Edge cases
//   - WIDTH=1: one SHIFT cycle; behaves as a registered full subtractor with borrow-in=0.
//   - Reset asserted mid-SHIFT aborts the operation; no done pulse is produced.
//   - Reset deasserted with start already high: start is accepted on the first edge after release.
// TESTING
//   1. WIDTH=8, a=200, b=55, start pulse -> done after 8 cycles, diff=145, borrow_out=0.
//   2. a=55, b=200 -> diff=111, borrow_out=1.
//      a=0, b=1 -> diff=255, borrow_out=1.
//      a=b=0 -> diff=0, borrow_out=0.
//   3. start pulsed again at SHIFT cycle 3 with a=1, b=1 -> ignored.
//      The first result is unchanged and exactly one done pulse is produced.
//   4. start held high across two operations (10-3, then 3-10):
//      -> done pulses 9 cycles apart; diff=7 with borrow_out=0, then diff=249 with borrow_out=1.
//   5. rst asserted at SHIFT cycle 4 -> busy, done, diff and borrow_out are 0 immediately.
//      No done pulse follows; the next start works normally.
//   6. WIDTH=4 exhaustive: all 256 (a,b) pairs checked against a reference model.
//      Expect diff==(a-b)&15, borrow_out==(a<b), and busy high for exactly 4 cycles each.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock.
// A single borrow flop links bit i to bit i+1. diff/borrow_out update only on the
// completing edge (or reset) and hold between operations.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter must index bits 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;
    logic             r_bq;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_b_nxt;
    logic             w_last;
    logic             w_load;

    // Full-subtract cell on the current LSBs with the stored borrow.
    assign w_d     = r_a_sh[0] ^ r_b_sh[0] ^ r_bq;
    assign w_b_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_bq);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // Result register fills from the MSB side so bit 0 lands at the bottom after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_d;
        end else begin : g_res_wn
            assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; DONE may accept a new start directly.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shift, and result publish on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res      <= '0;
            r_bq       <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (w_load) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= '0;
            r_bq   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= w_res_nxt;
            r_bq   <= w_b_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                diff       <= w_res_nxt;
                borrow_out <= w_b_nxt;
            end
        end
    end

endmodule
